// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared widths and default geometry for the instruction queue
package inst_queue_pkg;
  localparam int INST_SIZE    = 32;
  localparam int INST_WIDTH   = 32;
  localparam int IQ_DEPTH     = 16;
  localparam int IQ_AF_MARGIN = 2;
endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode side signals of the instruction queue
interface inst_queue_if;
  import inst_queue_pkg::*;

  logic                  push_en;
  logic [INST_SIZE-1:0]  push_inst;
  logic [INST_SIZE-1:0]  push_pc;
  logic                  iq_full;
  logic                  iq_almost_full;
  logic                  get_inst;
  logic [INST_WIDTH-1:0] inst_out;
  logic [INST_SIZE-1:0]  pc_out;
  logic                  en_out;
  logic                  iq_isempty;

  // fetch and decode together drive the queue
  modport master (
    output push_en, push_inst, push_pc, get_inst,
    input  iq_full, iq_almost_full, inst_out, pc_out, en_out, iq_isempty
  );

  // the queue itself
  modport slave (
    input  push_en, push_inst, push_pc, get_inst,
    output iq_full, iq_almost_full, inst_out, pc_out, en_out, iq_isempty
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular show-ahead FIFO of {instruction, pc} between fetch and decode
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_MARGIN = IQ_AF_MARGIN
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear,
  inst_queue_if.slave  iq
);

  localparam int            AF_LEVEL = DEPTH - AF_MARGIN;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];

  // storage is deliberately unreset so it can live in distributed RAM
  logic [INST_SIZE-1:0] mem_inst [DEPTH];
  logic [INST_SIZE-1:0] mem_pc   [DEPTH];

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic is_full;
  logic is_empty;
  logic push_ok;
  logic pop_ok;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);

  // freeze beats clear, clear beats push/pop; a push into a full queue is dropped even with a pop
  assign push_ok = rdy_in & ~clear & iq.push_en  & ~is_full;
  assign pop_ok  = rdy_in & ~clear & iq.get_inst & ~is_empty;

  assign iq.iq_full        = is_full;
  assign iq.iq_almost_full = (count >= AF_CNT);
  assign iq.iq_isempty     = is_empty;
  assign iq.en_out         = ~is_empty;
  assign iq.inst_out       = is_empty ? '0 : mem_inst[head];
  assign iq.pc_out         = is_empty ? '0 : mem_pc[head];

  // write the accepted entry at the tail slot
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_inst[tail] <= iq.push_inst;
      mem_pc[tail]   <= iq.push_pc;
    end
  end

  // pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_ok) tail <= tail + 1'b1;
        if (pop_ok)  head <= head + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
